// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a four-digit, common-decoder seven
// segment display. One 16-bit value (four hex nibbles) is shown one digit at
// a time; each digit stays lit for DWELL clock cycles, so a full frame is
// 4*DWELL cycles. New values are double-buffered: a load that arrives in the
// middle of a frame is parked in a shadow register and promoted at the next
// frame boundary, so a frame never mixes digits from two values.
//
// Parameters
//   DWELL        cycles each digit is shown (legal range 2 .. 2**20)
//
// Ports
//   clk          sole clock, rising-edge active
//   reset        synchronous, active-high reset (priority over run/load)
//   run          1 = scanning permitted, 0 = return to / stay in IDLE
//   load         one-cycle strobe capturing data_in
//   data_in      four nibbles, [3:0] = digit 0 (rightmost), [15:12] = digit 3
//   dig_nibble   nibble for the shared hex-to-7-segment decoder
//   dig_en       one-hot, active-high digit enable (bit i lights digit i)
//   frame_done   one-cycle pulse on the first cycle of each new frame
//   pending      a loaded value is waiting in the shadow register
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, digits 1..3 are dark during their
//                          slot if that digit and every digit to its left
//                          are zero. Digit 0 is always lit. Scan timing is
//                          identical with or without the option.
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int unsigned DWELL = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        load,
  input  logic [15:0] data_in,
  output logic [3:0]  dig_nibble,
  output logic [3:0]  dig_en,
  output logic        frame_done,
  output logic        pending
);

  // Divider just wide enough to hold DWELL-1.
  localparam int unsigned  CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DWELL - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Everything the digit driver needs, registered together.
  typedef struct packed {
    logic [3:0] en;
    logic [3:0] nibble;
  } disp_t;

  // Display word for a given value and digit slot. The enable is computed
  // from the same value that supplies the nibble, so blanking always agrees
  // with what would otherwise be shown.
  function automatic disp_t show(input logic [15:0] value,
                                 input logic [1:0]  index);
    disp_t d;
    d.en     = 4'b0001 << index;
    d.nibble = value[{index, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (index != 2'd0 && (value >> {index, 2'b00}) == 16'h0000)
      d.en = 4'b0000;
`endif
    return d;
  endfunction

  state_t         state;
  logic [CW-1:0]  div_cnt;
  logic [1:0]     idx;
  logic [15:0]    active;   // value currently being scanned
  logic [15:0]    shadow;   // value waiting for the next frame boundary
  disp_t          disp_q;

  // Next-cycle view of the datapath, shared by the state update and by the
  // registered display word so that both always see the same active value.
  logic           tick;
  logic           boundary;
  logic [CW-1:0]  div_nxt;
  logic [1:0]     idx_nxt;
  logic [15:0]    act_nxt;

  assign tick     = (state == SCAN) && (div_cnt == DIV_LAST);
  assign boundary = tick && (idx == 2'd3);

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    div_nxt = '0;
    idx_nxt = 2'd0;
    act_nxt = active;

    if (state == IDLE) begin
      // Starting a scan: a coincident load wins over a parked value, which
      // wins over whatever was being shown before scanning stopped.
      if (run) begin
        if (load)
          act_nxt = data_in;
        else if (pending)
          act_nxt = shadow;
      end
    end else begin
      if (tick) begin
        div_nxt = '0;
        idx_nxt = idx + 2'd1;   // wraps 3 -> 0 at the frame boundary
      end else begin
        div_nxt = div_cnt + CW'(1);
        idx_nxt = idx;
      end

      // Only a frame boundary may change the scanned value. A load on the
      // boundary itself goes straight to active and makes any older shadow
      // value stale.
      if (boundary) begin
        if (load)
          act_nxt = data_in;
        else if (pending)
          act_nxt = shadow;
      end
    end
  end

  // NOTE: all state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data registers are cleared too, not just the control
      // state; a run with no prior load must scan a known value of zero.
      state      <= IDLE;
      div_cnt    <= '0;
      idx        <= 2'd0;
      active     <= 16'h0000;
      shadow     <= 16'h0000;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      disp_q     <= '0;
    end else begin
      frame_done <= 1'b0;

      unique case (state)
        IDLE: begin
          div_cnt <= '0;
          idx     <= 2'd0;
          if (run) begin
            state   <= SCAN;
            active  <= act_nxt;
            pending <= 1'b0;
            disp_q  <= show(act_nxt, 2'd0);
          end else begin
            if (load) begin
              shadow  <= data_in;
              pending <= 1'b1;
            end
            disp_q <= '0;
          end
        end

        SCAN: begin
          if (!run) begin
            // Stop: go dark and rewind; active/shadow/pending survive so a
            // later restart resumes with the same value from digit 0.
            state   <= IDLE;
            div_cnt <= '0;
            idx     <= 2'd0;
            disp_q  <= '0;
            if (load) begin
              shadow  <= data_in;
              pending <= 1'b1;
            end
          end else begin
            div_cnt <= div_nxt;
            idx     <= idx_nxt;
            active  <= act_nxt;
            disp_q  <= show(act_nxt, idx_nxt);
            if (boundary) begin
              pending    <= 1'b0;
              frame_done <= 1'b1;
            end else if (load) begin
              // Mid-frame load: park it, last write wins.
              shadow  <= data_in;
              pending <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dig_en     = disp_q.en;
  assign dig_nibble = disp_q.nibble;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Self-checking bench for display_scan_ctrl with DWELL = 4 (one frame = 16
// cycles). Each scenario task drives one cycle at a time, pushes the output
// expected after that clock edge onto a scoreboard queue, and pops/compares
// it against the DUT on the following falling edge. Expected words come from
// the scenario's own description of what the display should be showing.
// Compile with +define+LEADING_ZERO_BLANK_EN on both files to exercise the
// blanking build; expectations follow the same macro.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int unsigned DWELL = 4;

  logic        clk;
  logic        reset;
  logic        run;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dig_nibble;
  logic [3:0]  dig_en;
  logic        frame_done;
  logic        pending;

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] nib;
    logic       fd;
    logic       pend;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  display_scan_ctrl #(.DWELL(DWELL)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .load       (load),
    .data_in    (data_in),
    .dig_nibble (dig_nibble),
    .dig_en     (dig_en),
    .frame_done (frame_done),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output while scanning value v in digit slot 'slot'.
  function automatic exp_t scan_exp(input logic [15:0] v, input int slot,
                                    input logic fd, input logic pend);
    exp_t e;
    e.en  = 4'b0001 << slot;
    e.nib = v[4*slot +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (slot != 0 && (v >> (4*slot)) == 16'h0000) e.en = 4'b0000;
`endif
    e.fd   = fd;
    e.pend = pend;
    return e;
  endfunction

  function automatic exp_t idle_exp(input logic pend);
    exp_t e;
    e = '0;
    e.pend = pend;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t o;
    o.en   = dig_en;
    o.nib  = dig_nibble;
    o.fd   = frame_done;
    o.pend = pending;
    return o;
  endfunction

  function automatic string fmt(input exp_t x);
    return $sformatf("en=%b nib=%h fd=%b pend=%b", x.en, x.nib, x.fd, x.pend);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; run = 1'b0; load = 1'b0; data_in = 16'h0000;
    step();
    reset = 1'b0;
  endtask

  // Reset clears everything and beats a coincident load/run.
  task automatic test_reset();
    exp_t e, obs;
    for (int k = 0; k < 4; k++) begin
      reset   = (k == 0);
      run     = (k == 0) || (k == 2);
      load    = (k == 0);
      data_in = 16'hFFFF;
      case (k)
        0, 1, 3: sb.push_back(idle_exp(1'b0));
        default: sb.push_back(scan_exp(16'h0000, 0, 1'b0, 1'b0));
      endcase
      step();
      obs = sample();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset k=%0d: got %s, want %s", k, fmt(obs), fmt(e));
      end
    end
  endtask

  // Load+run from IDLE, two full frames of 0x1234.
  task automatic test_scan_basic();
    exp_t e, obs;
    apply_reset();
    for (int k = 0; k < 34; k++) begin
      run = 1'b1; load = (k == 0); data_in = 16'h1234;
      sb.push_back(scan_exp(16'h1234, (k / 4) % 4, k > 0 && k % 16 == 0, 1'b0));
      step();
      obs = sample();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL scan_basic k=%0d: got %s, want %s", k, fmt(obs), fmt(e));
      end
    end
  endtask

  // Mid-frame load is deferred to the next frame boundary.
  task automatic test_pending_swap();
    exp_t e, obs;
    apply_reset();
    for (int k = 0; k < 21; k++) begin
      run = 1'b1;
      load = (k == 0) || (k == 5);
      data_in = (k == 5) ? 16'hABCD : 16'h1234;
      sb.push_back(scan_exp((k >= 16) ? 16'hABCD : 16'h1234, (k / 4) % 4,
                            k == 16, k >= 5 && k < 16));
      step();
      obs = sample();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL pending_swap k=%0d: got %s, want %s", k, fmt(obs), fmt(e));
      end
    end
  endtask

  // Two mid-frame loads: the later one wins, the earlier never shows.
  task automatic test_last_write();
    exp_t e, obs;
    apply_reset();
    for (int k = 0; k < 36; k++) begin
      run = 1'b1;
      load = (k == 0) || (k == 3) || (k == 9);
      data_in = (k == 3) ? 16'h1111 : (k == 9) ? 16'h2222 : 16'h1234;
      sb.push_back(scan_exp((k >= 16) ? 16'h2222 : 16'h1234, (k / 4) % 4,
                            k == 16 || k == 32, k >= 3 && k < 16));
      step();
      obs = sample();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL last_write k=%0d: got %s, want %s", k, fmt(obs), fmt(e));
      end
    end
  endtask

  // Load on a boundary cycle goes straight to active; a load on a later
  // boundary discards an older parked value.
  task automatic test_boundary_load();
    exp_t e, obs;
    logic [15:0] v;
    apply_reset();
    for (int k = 0; k < 51; k++) begin
      run = 1'b1;
      load = (k == 0) || (k == 16) || (k == 20) || (k == 32);
      case (k)
        16:      data_in = 16'h5555;
        20:      data_in = 16'h9999;
        32:      data_in = 16'h6666;
        default: data_in = 16'h1234;
      endcase
      v = (k < 16) ? 16'h1234 : (k < 32) ? 16'h5555 : 16'h6666;
      sb.push_back(scan_exp(v, (k / 4) % 4, k == 16 || k == 32 || k == 48,
                            k >= 20 && k < 32));
      step();
      obs = sample();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL boundary_load k=%0d: got %s, want %s", k, fmt(obs), fmt(e));
      end
    end
  endtask

  // run=0 mid-frame blanks next cycle; run=1 restarts at digit 0.
  task automatic test_run_stop();
    exp_t e, obs;
    apply_reset();
    for (int k = 0; k < 28; k++) begin
      run = !(k >= 6 && k < 10); load = (k == 0); data_in = 16'h1234;
      if (k < 6)
        sb.push_back(scan_exp(16'h1234, (k / 4) % 4, 1'b0, 1'b0));
      else if (k < 10)
        sb.push_back(idle_exp(1'b0));
      else
        sb.push_back(scan_exp(16'h1234, ((k - 10) / 4) % 4, k == 26, 1'b0));
      step();
      obs = sample();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL run_stop k=%0d: got %s, want %s", k, fmt(obs), fmt(e));
      end
    end
  endtask

  // Loads while stopped park in the shadow; run promotes the last one.
  task automatic test_idle_load();
    exp_t e, obs;
    apply_reset();
    for (int k = 0; k < 21; k++) begin
      run = (k >= 3);
      load = (k == 0) || (k == 2);
      data_in = (k == 2) ? 16'h0B0C : 16'h0F0A;
      if (k < 3)
        sb.push_back(idle_exp(1'b1));
      else
        sb.push_back(scan_exp(16'h0B0C, ((k - 3) / 4) % 4, k == 19, 1'b0));
      step();
      obs = sample();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL idle_load k=%0d: got %s, want %s", k, fmt(obs), fmt(e));
      end
    end
  endtask

  // Frame of 0x0070 (leading-zero digits dark when blanking is built in),
  // then reset mid-frame with a value pending, then a restart from zero.
  task automatic test_blank_and_reset();
    exp_t e, obs;
    apply_reset();
    for (int k = 0; k < 39; k++) begin
      reset   = (k == 18);
      run     = (k != 19);
      load    = (k == 0) || (k == 17);
      data_in = (k == 17) ? 16'h1234 : 16'h0070;
      if (k < 18)
        sb.push_back(scan_exp(16'h0070, (k / 4) % 4, k == 16, k == 17));
      else if (k < 20)
        sb.push_back(idle_exp(1'b0));
      else
        sb.push_back(scan_exp(16'h0000, ((k - 20) / 4) % 4, k == 36, 1'b0));
      step();
      obs = sample();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL blank_reset k=%0d: got %s, want %s", k, fmt(obs), fmt(e));
      end
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; load = 1'b0; data_in = 16'h0000;
    test_reset();
    test_scan_basic();
    test_pending_swap();
    test_last_write();
    test_boundary_load();
    test_run_stop();
    test_idle_load();
    test_blank_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter: DWELL, default 50000, number of Clock cycles each digit is shown; legal range 2..2^20.
REQ-002 Clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  1 = scanning permitted; 0 = force IDLE.
REQ-005 load  input  1  one-cycle strobe; capture data_in.
REQ-006 data_in  input  16  four hex nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-007 dig_nibble  output  4  nibble sent to the single shared hex-to-7-seg decoder.
REQ-008 dig_en  output  4  one-hot, active-high digit enable; bit i lights digit i.
REQ-009 frame_done  output  1  one-cycle pulse at each frame boundary.
REQ-010 pending  output  1  a loaded value is waiting in the shadow register.

Function
REQ-011 States: IDLE, SCAN; all outputs registered.
REQ-012 IDLE: dig_en = 0000, dig_nibble = 0000, divider and digit index held at 0.
REQ-013 IDLE with load=1 and run=1: active <= data_in; enter SCAN; the next cycle shows digit 0.
REQ-014 IDLE with load=1 and run=0: shadow <= data_in, pending <= 1; stay IDLE.
REQ-015 IDLE with run=1 and pending=1: active <= shadow, pending <= 0; enter SCAN.
REQ-016 SCAN divider counts 0..DWELL-1; tick when count = DWELL-1, then count wraps to 0.
REQ-017 On tick, digit index increments modulo 4; dig_en = 1 << index; dig_nibble = active[4*index+3 : 4*index].
REQ-018 Frame boundary is a tick with index 3 -> 0; frame_done = 1 on the following cycle only.
REQ-019 load in SCAN, not at a boundary: shadow <= data_in, pending <= 1; active unchanged (no tearing).
REQ-020 At a boundary with pending=1: active <= shadow, pending <= 0; digit 0 of the new frame shows the new value.
REQ-021 load coincident with a boundary: active <= data_in directly, pending <= 0; any older shadow is discarded.
REQ-022 load while pending=1: shadow overwritten; last write wins.
REQ-023 run=0 in SCAN: next cycle enter IDLE, dig_en = 0000, index and divider cleared; active, shadow and pending retained.
REQ-024 Each digit shows for exactly DWELL cycles; one frame = 4*DWELL cycles.

Reset
REQ-025 Reset=1 at an edge: state IDLE; active, shadow, divider and index = 0; dig_en = 0000, dig_nibble = 0000, frame_done = 0, pending = 0.
REQ-026 Reset has priority over load and run.
REQ-027 Reset mid-frame aborts the frame with no frame_done pulse.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN defined: during digit i's slot (i = 1..3), dig_en is 0000 if active nibbles i..3 are all zero; digit 0 is never blanked; timing is unchanged.
REQ-029 LEADING_ZERO_BLANK_EN undefined: every digit is lit in its slot regardless of value.

Verification (DWELL=4)
REQ-030 Reset, then run=1 and load with 0x1234: dig_en 0001/0010/0100/1000, each for 4 cycles; dig_nibble 4,3,2,1; frame_done pulses once every 16 cycles.
REQ-031 Load 0xABCD mid-frame while showing 0x1234: pending=1; the rest of the frame shows 0x1234; after the boundary pending=0 and digit 0 shows D.
REQ-032 Loads of 0x1111 then 0x2222 in one frame: the next frame shows 0x2222 only.
REQ-033 load 0x5555 on the boundary cycle: the next frame shows 0x5555; pending stays 0.
REQ-034 run=0 mid-frame: dig_en = 0000 next cycle; run=1 restarts at digit 0 with the retained value.
REQ-035 With LEADING_ZERO_BLANK_EN, active 0x0070: slots 3 and 2 give dig_en 0000; slots 1 and 0 are lit (7, 0). Reset asserted mid-frame: all outputs are 0 on the next cycle.
